// File: rtl/sram_avalon_ctrl.sv
// Avalon-MM slave to 16-bit asynchronous SRAM bridge with registered SRAM controls.
// state | meaning: IDLE accept | RD oe low | TURN bus release | WR_SETUP/WR_PULSE/WR_HOLD write phases
module sram_avalon_ctrl #(
  parameter int unsigned READ_WAIT  = 2,
  parameter int unsigned WRITE_WAIT = 2,
  parameter int unsigned TURNAROUND = 1
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic [17:0] avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [1:0]  avs_byteenable,
  input  logic [15:0] avs_writedata,
  output logic [15:0] avs_readdata,
  output logic        avs_waitrequest,
  output logic        avs_readdatavalid,
  output logic        sram_csN,
  output logic        sram_cs,
  output logic        sram_oeN,
  output logic        sram_weN,
  output logic [1:0]  sram_beN,
  output logic [17:0] sram_addr,
  inout  wire  [15:0] sram_dq
);

  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, TURN} state_t;

  localparam logic [3:0] RD_LOAD   = 4'(READ_WAIT - 1);
  localparam logic [3:0] WR_LOAD   = 4'(WRITE_WAIT - 1);
  localparam logic [3:0] TURN_LOAD = 4'(TURNAROUND - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [15:0] wdata_q, wdata_nxt;
  logic [1:0]  be_q, be_nxt;
  logic [17:0] addr_nxt;
  logic [15:0] rdata_nxt;
  logic        rdv_nxt;
  logic        cs_n_nxt, oe_n_nxt, we_n_nxt, dq_oe, dq_oe_nxt;
  logic [1:0]  be_n_nxt;

  assign avs_waitrequest = (state != IDLE);
  assign sram_cs         = ~sram_csN;
  assign sram_dq         = dq_oe ? wdata_q : 16'hzzzz;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wdata_nxt = wdata_q;
    be_nxt    = be_q;
    addr_nxt  = sram_addr;
    rdata_nxt = avs_readdata;
    rdv_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (avs_write || avs_read) begin
          addr_nxt  = avs_address;
          wdata_nxt = avs_writedata;
          be_nxt    = avs_byteenable;
        end
        // write wins when both commands arrive together
        if (avs_write) begin
          state_nxt = WR_SETUP;
        end else if (avs_read) begin
          state_nxt = RD;
          cnt_nxt   = RD_LOAD;
        end
      end
      RD: begin
        if (cnt == 4'd0) begin
          state_nxt = TURN;
          cnt_nxt   = TURN_LOAD;
          rdata_nxt = sram_dq;
          rdv_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      TURN: begin
        if (cnt == 4'd0) state_nxt = IDLE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      WR_SETUP: begin
        state_nxt = WR_PULSE;
        cnt_nxt   = WR_LOAD;
      end
      WR_PULSE: begin
        if (cnt == 4'd0) state_nxt = WR_HOLD;
        else             cnt_nxt   = cnt - 4'd1;
      end
      WR_HOLD: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // SRAM strobes are decoded from the next state so they leave the flops aligned with it
  always_comb begin
    cs_n_nxt  = 1'b1;
    oe_n_nxt  = 1'b1;
    we_n_nxt  = 1'b1;
    be_n_nxt  = 2'b11;
    dq_oe_nxt = 1'b0;
    case (state_nxt)
      RD: begin
        cs_n_nxt = 1'b0;
        oe_n_nxt = 1'b0;
        be_n_nxt = 2'b00;
      end
      WR_SETUP, WR_HOLD: begin
        cs_n_nxt  = 1'b0;
        be_n_nxt  = ~be_nxt;
        dq_oe_nxt = 1'b1;
      end
      WR_PULSE: begin
        cs_n_nxt  = 1'b0;
        we_n_nxt  = 1'b0;
        be_n_nxt  = ~be_nxt;
        dq_oe_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state             <= IDLE;
      cnt               <= 4'd0;
      wdata_q           <= 16'd0;
      be_q              <= 2'b00;
      sram_addr         <= 18'd0;
      sram_csN          <= 1'b1;
      sram_oeN          <= 1'b1;
      sram_weN          <= 1'b1;
      sram_beN          <= 2'b11;
      dq_oe             <= 1'b0;
      avs_readdata      <= 16'd0;
      avs_readdatavalid <= 1'b0;
    end else begin
      state             <= state_nxt;
      cnt               <= cnt_nxt;
      wdata_q           <= wdata_nxt;
      be_q              <= be_nxt;
      sram_addr         <= addr_nxt;
      sram_csN          <= cs_n_nxt;
      sram_oeN          <= oe_n_nxt;
      sram_weN          <= we_n_nxt;
      sram_beN          <= be_n_nxt;
      dq_oe             <= dq_oe_nxt;
      avs_readdata      <= rdata_nxt;
      avs_readdatavalid <= rdv_nxt;
    end
  end

endmodule

// File: doc/sram_avalon_ctrl.md
SRAM_AVALON_CTRL -- requirements
Module: sram_avalon_ctrl

Interface
REQ-001 Parameter READ_WAIT, default 2, OE-active cycles per read; legal range 1..15.
REQ-002 Parameter WRITE_WAIT, default 2, WE-low cycles per write; legal range 1..15.
REQ-003 Parameter TURNAROUND, default 1, bus-idle cycles after a read; legal range 1..15.
REQ-004 clk  input  1  system clock.
REQ-005 rstN  input  1  reset, asynchronous, active-low.
REQ-006 avs_address  input  18  16-bit word address.
REQ-007 avs_read / avs_write  input  1 each  Avalon-MM read and write commands.
REQ-008 avs_byteenable  input  2  write byte lanes; bit0 = dq[7:0].
REQ-009 avs_writedata  input  16  write data.
REQ-010 avs_readdata  output  16  read data; valid only while avs_readdatavalid is high.
REQ-011 avs_waitrequest  output  1  high while a command cannot be accepted.
REQ-012 avs_readdatavalid  output  1  single-cycle read-data strobe.
REQ-013 sram_csN / sram_cs  output  1 each  chip selects; sram_cs always equals ~sram_csN.
REQ-014 sram_oeN / sram_weN  output  1 each  output enable and write enable, active-low.
REQ-015 sram_beN  output  2  byte enables, active-low.
REQ-016 sram_addr  output  18  SRAM address.
REQ-017 sram_dq  inout  16  SRAM data bus.

Function
REQ-018 The FSM SHALL have the states IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD and TURN, plus a 4-bit wait counter.
REQ-019 avs_waitrequest SHALL be low only in IDLE; a command is accepted on the clock edge where it is high and avs_waitrequest is low.
REQ-020 On accept, the block SHALL register avs_address, avs_writedata and avs_byteenable; bus changes after accept are ignored.
REQ-021 When read and write are both asserted at accept, the write SHALL be performed, the read dropped, and no readdatavalid generated.
REQ-022 Read path: IDLE -> RD for READ_WAIT cycles, with csN=0, oeN=0, beN=00 and addr driven.
REQ-023 Read path: sram_dq SHALL be sampled into avs_readdata on the final RD edge.
REQ-024 Read path: RD -> TURN for TURNAROUND cycles with csN=1, oeN=1; TURN -> IDLE.
REQ-025 avs_readdatavalid SHALL be high for exactly the first TURN cycle, READ_WAIT+1 cycles after accept.
REQ-026 Write path: WR_SETUP lasts 1 cycle, with csN=0, weN=1, addr, beN=~byteenable and dq driven.
REQ-027 Write path: WR_PULSE lasts WRITE_WAIT cycles, with weN=0 and all other write signals held.
REQ-028 Write path: WR_HOLD lasts 1 cycle, with weN=1 and csN, addr and dq held; WR_HOLD -> IDLE.
REQ-029 avs_waitrequest SHALL be high for WRITE_WAIT+2 cycles per write and READ_WAIT+TURNAROUND cycles per read.
REQ-030 sram_dq SHALL be driven only in WR_SETUP, WR_PULSE and WR_HOLD, and SHALL be Z otherwise.
REQ-031 sram_oeN and sram_weN SHALL never be low together.
REQ-032 oeN SHALL be high for at least 1 cycle before dq is driven.
REQ-033 A write with byteenable=00 SHALL run full timing with beN=11.
REQ-034 Address 0x3FFFF SHALL be handled like any other address, with no wrap or carry logic.
REQ-035 All SRAM control outputs SHALL be registered, with no combinational path from avs_* to sram_*.
REQ-036 In IDLE, the block SHALL drive csN=1, oeN=1, weN=1, beN=11, and hold addr at its last value.

Reset
REQ-037 While rstN is low, the block SHALL output: state IDLE; csN=1, cs=0, oeN=1, weN=1, beN=11, addr=0, dq=Z.
REQ-038 While rstN is low, the block SHALL output: avs_readdata=0, avs_readdatavalid=0, avs_waitrequest=0.
REQ-039 Reset asserted mid-operation SHALL force the REQ-037/038 values immediately (asynchronously), abort the cycle and suppress any pending readdatavalid.
REQ-040 The first command SHALL be accepted on the first edge after rstN deasserts.

Verification (READ_WAIT=2, WRITE_WAIT=2, TURNAROUND=1)
REQ-041 Write 0x1234 to 0x00005, be=11 -> csN low 4 cycles, weN low cycles 2-3, dq=0x1234, beN=00, waitrequest high 4 cycles.
REQ-042 Read 0x00005, model returns 0x1234 -> oeN low 2 cycles, readdatavalid high 3 cycles after accept for 1 cycle, readdata=0x1234.
REQ-043 Write 0xABCD to 0x3FFFF, be=01 -> beN=10, addr=0x3FFFF; then read back -> upper byte unchanged from model, lower byte=0xCD.
REQ-044 Back-to-back read then write -> 1 TURN cycle with dq=Z and oeN=1 before WR_SETUP; checker confirms no dq contention.
REQ-045 rstN pulsed low during WR_PULSE -> weN=1, csN=1, dq=Z within the same cycle; no readdatavalid; next command accepted normally.
REQ-046 read=write=1 with addr 0x00010, data 0x5555 -> write occurs, no readdatavalid.
